// File: rtl/game_ctrl.sv
// Typing-game sequencer: SELECT -> COUNTDOWN -> INGAME -> FINISH, with
// front-panel selection of game mode/length. Runs on the 100 Hz clk_div tick.
module game_ctrl #(
  parameter int TICKS_PER_SEC = 100,
  parameter int COUNT_SEC     = 3,
  parameter int TIME_MIN      = 15,
  parameter int TIME_MAX      = 60,
  parameter int TIME_STEP     = 15,
  parameter int WORD_MIN      = 10,
  parameter int WORD_MAX      = 50,
  parameter int WORD_STEP     = 10
) (
  input  logic       rst,
  input  logic       clk_div,
  input  logic       btn_start,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       finish,
  output logic [1:0] state,
  output logic       mode,
  output logic [6:0] value,
  output logic [1:0] countdown,
  output logic       go
);
  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [1:0] {
    SELECT    = 2'd0,
    COUNTDOWN = 2'd1,
    INGAME    = 2'd2,
    FINISH    = 2'd3
  } state_e;

  state_e        state_q;
  logic          mode_q, go_q;
  logic [6:0]    value_q;
  logic [1:0]    sec_q, countdown_q;
  logic [TW-1:0] tick_q;
  logic [3:0]    prev_q;

  logic [3:0] btn, edge_w;
  logic       start_e, mode_e, up_e, down_e;
  logic [7:0] v_max, v_min, v_step, up_sum;
  logic [6:0] up_val, dn_val;

  assign btn     = {btn_down, btn_up, btn_mode, btn_start};
  assign edge_w  = btn & ~prev_q;
  assign start_e = edge_w[0];
  assign mode_e  = edge_w[1];
  assign up_e    = edge_w[2];
  assign down_e  = edge_w[3];

  // Saturating step arithmetic in 8 bits so value+step cannot wrap.
  assign v_max  = mode_q ? 8'(WORD_MAX)  : 8'(TIME_MAX);
  assign v_min  = mode_q ? 8'(WORD_MIN)  : 8'(TIME_MIN);
  assign v_step = mode_q ? 8'(WORD_STEP) : 8'(TIME_STEP);
  assign up_sum = {1'b0, value_q} + v_step;
  assign up_val = (up_sum > v_max) ? v_max[6:0] : up_sum[6:0];
  assign dn_val = ({1'b0, value_q} < v_min + v_step) ? v_min[6:0]
                                                     : value_q - v_step[6:0];

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state_q     <= SELECT;
      mode_q      <= 1'b0;
      value_q     <= 7'(TIME_MIN);
      sec_q       <= 2'd0;
      tick_q      <= '0;
      countdown_q <= 2'd0;
      go_q        <= 1'b0;
      prev_q      <= 4'hF;
    end else begin
      prev_q <= btn;
      go_q   <= 1'b0;
      case (state_q)
        SELECT: begin
          if (start_e) begin
            state_q     <= COUNTDOWN;
            sec_q       <= 2'(COUNT_SEC);
            tick_q      <= '0;
            countdown_q <= 2'(COUNT_SEC);
          end else if (mode_e) begin
            mode_q  <= ~mode_q;
            value_q <= mode_q ? 7'(TIME_MIN) : 7'(WORD_MIN);
          end else if (up_e) begin
            value_q <= up_val;
          end else if (down_e) begin
            value_q <= dn_val;
          end
        end
        COUNTDOWN: begin
          if (start_e) begin
            state_q     <= SELECT;
            sec_q       <= 2'd0;
            tick_q      <= '0;
            countdown_q <= 2'd0;
          end else if (tick_q == TW'(TICKS_PER_SEC - 1)) begin
            tick_q <= '0;
            if (sec_q == 2'd1) begin
              state_q     <= INGAME;
              go_q        <= 1'b1;
              sec_q       <= 2'd0;
              countdown_q <= 2'd0;
            end else begin
              sec_q       <= sec_q - 2'd1;
              countdown_q <= sec_q - 2'd1;
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        INGAME: begin
          if (finish)       state_q <= FINISH;
          else if (start_e) state_q <= SELECT;
        end
        FINISH: begin
          if (start_e) state_q <= SELECT;
        end
        default: state_q <= SELECT;
      endcase
    end
  end

  assign state     = state_q;
  assign mode      = mode_q;
  assign value     = value_q;
  assign countdown = countdown_q;
  assign go        = go_q;
endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: button selection, countdown timing, abort,
// finish priority and reset behaviour, checked with immediate assertions.
module tb_game_ctrl;
  logic       rst, clk_div;
  logic       btn_start, btn_mode, btn_up, btn_down, finish;
  logic [1:0] state, countdown;
  logic       mode, go;
  logic [6:0] value;

  int n_chk = 0;
  int n_fail = 0;

  game_ctrl dut (
    .rst(rst), .clk_div(clk_div),
    .btn_start(btn_start), .btn_mode(btn_mode),
    .btn_up(btn_up), .btn_down(btn_down), .finish(finish),
    .state(state), .mode(mode), .value(value),
    .countdown(countdown), .go(go)
  );

  initial clk_div = 1'b0;
  always #5 clk_div = ~clk_div;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_div);
  endtask

  // 0=start 1=mode 2=up 3=down; one-cycle press, returns when result is visible
  task automatic press(input int b);
    @(negedge clk_div);
    case (b)
      0: btn_start = 1'b1;
      1: btn_mode  = 1'b1;
      2: btn_up    = 1'b1;
      default: btn_down = 1'b1;
    endcase
    @(negedge clk_div);
    btn_start = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
  endtask

  task automatic run_countdown(input string tag);
    chk({tag, "_st0"}, state, 1);
    chk({tag, "_cd0"}, countdown, 3);
    for (int c = 1; c <= 301; c++) begin
      step(1);
      if (c == 99)  chk({tag, "_cd99"},  countdown, 3);
      if (c == 100) chk({tag, "_cd100"}, countdown, 2);
      if (c == 200) chk({tag, "_cd200"}, countdown, 1);
      if (c == 299) begin
        chk({tag, "_st299"}, state, 1);
        chk({tag, "_go299"}, go, 0);
      end
      if (c == 300) begin
        chk({tag, "_st300"}, state, 2);
        chk({tag, "_go300"}, go, 1);
        chk({tag, "_cd300"}, countdown, 0);
      end
      if (c == 301) chk({tag, "_go301"}, go, 0);
    end
  endtask

  initial begin
    rst = 1'b1; finish = 1'b0;
    btn_start = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    step(3);
    chk("rst_state", state, 0);
    chk("rst_mode", mode, 0);
    chk("rst_value", value, 15);
    chk("rst_cd", countdown, 0);
    chk("rst_go", go, 0);
    rst = 1'b0;
    step(2);

    // value selection in timed mode
    press(2); chk("up1", value, 30);
    press(2); chk("up2", value, 45);
    press(2); chk("up3", value, 60);
    press(2); chk("up4_sat", value, 60);
    press(2); chk("up5_sat", value, 60);
    press(3); chk("dn1", value, 45);
    press(3); press(3); chk("dn3", value, 15);
    press(3); press(3); chk("dn5_sat", value, 15);

    // held button only steps once
    @(negedge clk_div); btn_up = 1'b1;
    step(4);
    chk("held_up", value, 30);
    btn_up = 1'b0;
    press(3); chk("held_back", value, 15);

    // mode+up in the same cycle: mode wins, up ignored
    @(negedge clk_div); btn_mode = 1'b1; btn_up = 1'b1;
    @(negedge clk_div); btn_mode = 1'b0; btn_up = 1'b0;
    chk("prio_mode", mode, 1);
    chk("prio_value", value, 10);
    for (int i = 0; i < 6; i++) press(2);
    chk("word_up6", value, 50);
    chk("sel_state", state, 0);

    // full countdown into INGAME
    press(0);
    run_countdown("cd1");

    // finish and start together: finish wins
    @(negedge clk_div); finish = 1'b1; btn_start = 1'b1;
    @(negedge clk_div); btn_start = 1'b0;
    chk("fin_prio", state, 3);
    finish = 1'b0;
    press(2);
    chk("fin_ignore_up", value, 50);
    chk("fin_hold", state, 3);
    press(0);
    chk("fin_exit", state, 0);

    // abort mid-countdown
    press(0);
    step(149);
    chk("ab_cd149", countdown, 2);
    press(0);
    chk("ab_state", state, 0);
    chk("ab_cd", countdown, 0);
    chk("ab_mode", mode, 1);
    chk("ab_value", value, 50);
    press(0);
    run_countdown("cd2");

    // async reset in INGAME with buttons held through release
    @(negedge clk_div);
    rst = 1'b1; btn_start = 1'b1; btn_up = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_mode", mode, 0);
    chk("arst_value", value, 15);
    step(2);
    rst = 1'b0;
    step(3);
    chk("held_rst_state", state, 0);
    chk("held_rst_value", value, 15);
    btn_start = 1'b0; btn_up = 1'b0;
    step(1);
    press(0);
    chk("post_rst_start", state, 1);
    chk("post_rst_cd", countdown, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
